// File: rtl/fp_round_pack.sv
// Normalizes, rounds and packs a sign/exponent/significand triple into an IEEE-754 binary format.
// A multi-cycle FSM applies one normalization shift per cycle and then does a single rounding step.
module fp_round_pack #(
  parameter int NEXP = 5,
  parameter int NSIG = 10,
  localparam int NTYPES = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_sign,
  input  logic signed [NEXP+1:0] in_exp,
  input  logic [NSIG+3:0]        in_sig,
  input  logic                   in_sticky,
  input  logic [NTYPES-1:0]      in_flags,
  input  logic [1:0]             rm,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NEXP+NSIG:0]     out_f,
  output logic [3:0]             out_exc
);
  localparam int SNAN = 0, QNAN = 1, INFINITY = 2, ZERO = 3, SUBNORMAL = 4, NORMAL = 5;
  localparam int BIAS = (1 << (NEXP - 1)) - 1;
  localparam int EMIN = 1 - BIAS;
  localparam int EMAX = BIAS;
  localparam int EW = NEXP + 3;
  localparam int SW = NSIG + 4;
  localparam int FW = NEXP + NSIG + 1;

  localparam logic signed [EW-1:0] EMIN_E  = EW'(EMIN);
  localparam logic signed [EW-1:0] EMAX_E  = EW'(EMAX);
  localparam logic signed [EW-1:0] FLUSH_E = EW'(EMIN - SW);
  localparam logic signed [EW-1:0] ONE_E   = EW'(1);
  localparam logic [NEXP-1:0]      BIAS_F  = NEXP'(BIAS);
  localparam logic [FW-1:0] QNAN_F = {1'b0, {NEXP{1'b1}}, 1'b1, {(NSIG-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

  state_t state, state_nx;

  logic                 op_sign;
  logic [1:0]           op_rm;
  logic signed [EW-1:0] op_exp;
  logic [SW-1:0]        op_sig;
  logic                 op_sticky;

  function automatic logic round_inc(input logic [1:0] mode, input logic sgn,
                                     input logic lsb, input logic g, input logic s);
    case (mode)
      2'd0:    return g & (s | lsb);
      2'd1:    return 1'b0;
      2'd2:    return ~sgn & (g | s);
      default: return sgn & (g | s);
    endcase
  endfunction

  // Overflow saturates to max finite unless the mode rounds away from zero in this sign.
  function automatic logic [FW-1:0] ovf_result(input logic sgn, input logic [1:0] mode);
    logic to_inf;
    to_inf = (mode == 2'd0) || (mode == 2'd2 && !sgn) || (mode == 2'd3 && sgn);
    if (to_inf)
      return {sgn, {NEXP{1'b1}}, {NSIG{1'b0}}};
    else
      return {sgn, {(NEXP-1){1'b1}}, 1'b0, {NSIG{1'b1}}};
  endfunction

  logic norm_class, sig_zero, flush, shr, shl, norm_done;

  assign norm_class = in_flags[NORMAL] | in_flags[SUBNORMAL];
  assign sig_zero   = (op_sig == '0) && !op_sticky;
  assign flush      = op_exp < FLUSH_E;
  assign shr        = op_sig[SW-1] || (op_exp < EMIN_E);
  assign shl        = !op_sig[SW-2] && (op_exp > EMIN_E);
  assign norm_done  = sig_zero || (!flush && !shr && !shl);

  logic [FW-1:0] spec_f;
  logic [3:0]    spec_exc;

  always_comb begin
    spec_f   = QNAN_F;
    spec_exc = 4'b0000;
    if (in_flags[SNAN]) begin
      spec_exc = 4'b1000;
    end else if (in_flags[QNAN]) begin
      spec_f = QNAN_F;
    end else if (in_flags[INFINITY]) begin
      spec_f = {in_sign, {NEXP{1'b1}}, {NSIG{1'b0}}};
    end else if (in_flags[ZERO]) begin
      spec_f = {in_sign, {(FW-1){1'b0}}};
    end
  end

  logic             lsb, g, s, inc, carry, tiny, inexact, ovf;
  logic [NSIG+1:0]  man_sum;
  logic [NSIG:0]    man;
  logic signed [EW-1:0] exp_rnd;
  logic [NEXP-1:0]  exp_field;
  logic [FW-1:0]    rnd_f;
  logic [3:0]       rnd_exc;

  // ROUND stage: increment, renormalize on carry to 2.0, then encode.
  always_comb begin
    lsb       = op_sig[2];
    g         = op_sig[1];
    s         = op_sig[0] | op_sticky;
    inc       = round_inc(op_rm, op_sign, lsb, g, s);
    man_sum   = {1'b0, op_sig[SW-2:2]} + {{(NSIG+1){1'b0}}, inc};
    carry     = man_sum[NSIG+1];
    man       = carry ? man_sum[NSIG+1:1] : man_sum[NSIG:0];
    exp_rnd   = carry ? op_exp + ONE_E : op_exp;
    exp_field = man[NSIG] ? exp_rnd[NEXP-1:0] + BIAS_F : {NEXP{1'b0}};
    tiny      = !op_sig[SW-2] && (op_exp == EMIN_E);
    inexact   = g | s;
    ovf       = man[NSIG] && (exp_rnd > EMAX_E);
    rnd_f     = {op_sign, exp_field, man[NSIG-1:0]};
    rnd_exc   = {2'b00, tiny & inexact, inexact};
    if (ovf) begin
      rnd_f   = ovf_result(op_sign, op_rm);
      rnd_exc = 4'b0101;
    end
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = norm_class ? NORM : DONE;
      end
      NORM:  if (norm_done) state_nx = ROUND;
      ROUND: state_nx = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      out_f   <= '0;
      out_exc <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && in_valid && !norm_class) begin
        out_f   <= spec_f;
        out_exc <= spec_exc;
      end else if (state == ROUND) begin
        out_f   <= rnd_f;
        out_exc <= rnd_exc;
      end
    end
  end

  // NORM stage: one shift or one flush per cycle; the exponent register is wide enough never to wrap.
  always_ff @(posedge clk) begin
    case (state)
      IDLE: if (in_valid) begin
        op_sign   <= in_sign;
        op_rm     <= rm;
        op_exp    <= {in_exp[NEXP+1], in_exp};
        op_sig    <= in_sig;
        op_sticky <= in_sticky;
      end
      NORM: if (!sig_zero) begin
        if (flush) begin
          op_exp    <= EMIN_E;
          op_sticky <= op_sticky | (|op_sig);
          op_sig    <= '0;
        end else if (shr) begin
          op_sig    <= op_sig >> 1;
          op_exp    <= op_exp + ONE_E;
          op_sticky <= op_sticky | op_sig[0];
        end else if (shl) begin
          op_sig    <= op_sig << 1;
          op_exp    <= op_exp - ONE_E;
        end
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_fp_round_pack.sv
// Directed bench for fp_round_pack at NEXP=5, NSIG=10 with hand-computed half-precision results.
module tb_fp_round_pack;
  localparam int SNAN = 0, QNAN = 1, INFINITY = 2, ZERO = 3, SUBNORMAL = 4, NORMAL = 5;

  logic              clk = 1'b0;
  logic              rst, in_valid, in_ready, in_sign, in_sticky, out_valid, out_ready;
  logic signed [6:0] in_exp;
  logic [13:0]       in_sig;
  logic [5:0]        in_flags;
  logic [1:0]        rm;
  logic [15:0]       out_f;
  logic [3:0]        out_exc;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  fp_round_pack #(.NEXP(5), .NSIG(10)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_sig(in_sig), .in_sticky(in_sticky),
    .in_flags(in_flags), .rm(rm), .out_valid(out_valid), .out_ready(out_ready),
    .out_f(out_f), .out_exc(out_exc)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic run_op(input string tag, input int cls, input logic sgn, input int e,
                        input logic [13:0] sg, input logic stk, input logic [1:0] mode,
                        input logic [15:0] ef, input logic [3:0] ex, input int lat,
                        input int hold);
    int n;
    logic [31:0] ev;
    @(negedge clk);
    ev        = e;
    in_exp    = ev[6:0];
    in_sign   = sgn;
    in_sig    = sg;
    in_sticky = stk;
    rm        = mode;
    in_flags  = 6'(1 << cls);
    in_valid  = 1'b1;
    check({tag, ".ready"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid  = 1'b0;
    in_flags  = '0;
    in_sig    = 14'h3FFF;
    in_sign   = ~sgn;
    rm        = ~mode;
    n = 0;
    while (!out_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, ".lat"}, n, lat);
    check({tag, ".f"}, out_f, ef);
    check({tag, ".exc"}, out_exc, ex);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      in_flags = 6'(1 << ZERO);
      @(posedge clk); #1;
      check({tag, ".hold_f"}, out_f, ef);
      check({tag, ".hold_exc"}, out_exc, ex);
      check({tag, ".hold_valid"}, out_valid, 1);
      check({tag, ".hold_ready"}, in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, ".idle_ready"}, in_ready, 1);
    check({tag, ".idle_valid"}, out_valid, 0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_sign = 1'b0; in_exp = '0;
    in_sig = '0; in_sticky = 1'b0; in_flags = '0; rm = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.ready", in_ready, 1);
    check("rst.valid", out_valid, 0);
    check("rst.f", out_f, 0);
    check("rst.exc", out_exc, 0);
    rst = 1'b0;

    //     tag          class      sg  exp  sig       stk   rm    out_f     exc  lat hold
    run_op("one",       NORMAL,    0,  0,   14'h1000, 1'b0, 2'd0, 16'h3C00, 4'h0, 2, 0);
    run_op("sub",       SUBNORMAL, 0, -15,  14'h1000, 1'b0, 2'd0, 16'h0200, 4'h0, 3, 0);
    run_op("ovf_rne",   NORMAL,    0,  16,  14'h1000, 1'b0, 2'd0, 16'h7C00, 4'h5, 2, 0);
    run_op("ovf_rtz",   NORMAL,    0,  16,  14'h1000, 1'b0, 2'd1, 16'h7BFF, 4'h5, 2, 0);
    run_op("ovf_rupn",  NORMAL,    1,  16,  14'h1000, 1'b0, 2'd2, 16'hFBFF, 4'h5, 2, 0);
    run_op("ovf_rdnn",  NORMAL,    1,  16,  14'h1000, 1'b0, 2'd3, 16'hFC00, 4'h5, 2, 0);
    run_op("carry",     NORMAL,    0,  0,   14'h1FFE, 1'b0, 2'd0, 16'h4000, 4'h1, 2, 0);
    run_op("three",     NORMAL,    0,  0,   14'h3000, 1'b0, 2'd0, 16'h4200, 4'h0, 3, 0);
    run_op("quarter",   NORMAL,    0,  0,   14'h0400, 1'b0, 2'd0, 16'h3400, 4'h0, 4, 0);
    run_op("rdn_neg",   NORMAL,    1,  0,   14'h1001, 1'b0, 2'd3, 16'hBC01, 4'h1, 2, 0);
    run_op("tie_even",  NORMAL,    0,  0,   14'h1002, 1'b0, 2'd0, 16'h3C00, 4'h1, 2, 0);
    run_op("uflow",     SUBNORMAL, 0, -15,  14'h1004, 1'b0, 2'd0, 16'h0200, 4'h3, 3, 0);
    run_op("sub_carry", SUBNORMAL, 0, -14,  14'h0FFE, 1'b0, 2'd0, 16'h0400, 4'h3, 2, 0);
    run_op("flush",     SUBNORMAL, 0, -40,  14'h1000, 1'b0, 2'd2, 16'h0001, 4'h3, 3, 0);
    run_op("zero_sig",  NORMAL,    1,  3,   14'h0000, 1'b0, 2'd0, 16'h8000, 4'h0, 2, 0);
    run_op("zero",      ZERO,      1,  0,   14'h0000, 1'b0, 2'd0, 16'h8000, 4'h0, 0, 0);
    run_op("inf",       INFINITY,  0,  0,   14'h0000, 1'b0, 2'd0, 16'h7C00, 4'h0, 0, 0);
    run_op("qnan",      QNAN,      1,  0,   14'h0000, 1'b0, 2'd0, 16'h7E00, 4'h0, 0, 0);
    run_op("snan",      SNAN,      0,  0,   14'h0000, 1'b0, 2'd0, 16'h7E00, 4'h8, 0, 3);

    // Abort a long normalization with an asynchronous reset pulse.
    @(negedge clk);
    in_exp = '0; in_sig = 14'h0001; in_sticky = 1'b0; in_sign = 1'b0; rm = 2'd0;
    in_flags = 6'(1 << NORMAL); in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("abort.busy_ready", in_ready, 0);
    rst = 1'b1;
    #1;
    check("abort.valid", out_valid, 0);
    check("abort.ready", in_ready, 1);
    check("abort.f", out_f, 0);
    check("abort.exc", out_exc, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_op("post_rst",  NORMAL,    0,  0,   14'h1000, 1'b0, 2'd0, 16'h3C00, 4'h0, 2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/fp_round_pack.md
FP_ROUND_PACK -- requirements
Module: fp_round_pack

Interface
REQ-001 Parameter NEXP, default 5, exponent field width.
REQ-002 Parameter NSIG, default 10, stored fraction width. BIAS, EMIN, EMAX and the flag indices NTYPES, SNAN, QNAN, INFINITY, ZERO, SUBNORMAL and NORMAL SHALL come from the team's IEEE-754 flags include.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  input operand valid.
REQ-006 in_ready  output  1  block can accept an operand; high only in state IDLE.
REQ-007 in_sign  input  1  result sign.
REQ-008 in_exp  input  signed NEXP+2  unbiased exponent.
REQ-009 in_sig  input  NSIG+4  significand. Bit NSIG+2 has weight 2^0 and bit NSIG+3 has weight 2^1. Bits 1:0 are guard and round.
REQ-010 in_sticky  input  1  OR of discarded lower bits.
REQ-011 in_flags  input  NTYPES  operand class, one-hot, same encoding as the unpack side.
REQ-012 rm  input  2  rounding mode: 0 RNE, 1 RTZ, 2 RUP (toward +inf), 3 RDN (toward -inf).
REQ-013 out_valid  output  1  result valid.
REQ-014 out_ready  input  1  consumer accepts the result.
REQ-015 out_f  output  NEXP+NSIG+1  packed IEEE result.
REQ-016 out_exc  output  4  exception flags {invalid, overflow, underflow, inexact}.

Function
REQ-017 The FSM SHALL have four states: IDLE, NORM, ROUND and DONE.
REQ-018 An operand SHALL be accepted on an edge where in_valid and in_ready are both high. All inputs, including rm, are captured on that edge.
REQ-019 For an accepted NORMAL or SUBNORMAL operand, the FSM SHALL go IDLE->NORM. For any other class it SHALL go IDLE->DONE.
- SNAN: out_f = canonical qNaN (sign 0, exponent all ones, fraction MSB 1, remaining bits 0), invalid = 1.
- QNAN: out_f = canonical qNaN, no flags.
- INFINITY: out_f = signed infinity, no flags.
- ZERO: out_f = signed zero, no flags.
REQ-020 The exponent SHALL be held in a signed internal register of NEXP+3 bits; it SHALL never wrap.
REQ-021 NORM SHALL perform at most one shift per cycle, checked in this priority order:
- sig all zero and sticky 0 -> exit.
- bit NSIG+3 set, or exp < EMIN -> right shift by 1, exp+1, shifted-out bit ORed into sticky.
- bit NSIG+2 clear and exp > EMIN -> left shift by 1, exp-1.
- otherwise -> exit to ROUND.
REQ-022 If exp < EMIN - (NSIG+4), a single NORM cycle SHALL set exp = EMIN, OR all sig bits into sticky, and clear sig.
REQ-023 ROUND SHALL use lsb = sig[2], G = sig[1], S = sig[0] | sticky to compute the increment:
- RNE: G & (S | lsb).
- RTZ: 0.
- RUP: ~sign & (G | S).
- RDN: sign & (G | S).
REQ-024 Rounding carry: if the rounded significand reaches 2.0, ROUND SHALL shift it right by 1 and add 1 to exp. A carry out of a subnormal SHALL produce the minimum normal.
REQ-025 Encoding:
- Hidden bit 1: biased exponent = exp + BIAS.
- Hidden bit 0 at EMIN: biased exponent = 0.
- Zero significand: signed zero.
REQ-026 Overflow occurs when the rounded exp > EMAX. It SHALL set overflow and inexact. out_f SHALL be infinity for RNE, for RUP with sign 0 and for RDN with sign 1; otherwise it SHALL be the maximum finite value.
REQ-027 inexact = G | S.
REQ-028 underflow = tiny-before-rounding (hidden bit 0 at EMIN after NORM) & inexact.
REQ-029 ROUND->DONE SHALL take exactly one cycle. out_f and out_exc SHALL be registered on entry to DONE.
REQ-030 Latency:
- With k NORM shifts, out_valid SHALL rise after edge k+2 following the accepting edge.
- For special classes, out_valid SHALL rise after the accepting edge.
REQ-031 In DONE, out_valid SHALL be 1 and out_f/out_exc SHALL stay stable until an edge where out_ready = 1; that edge SHALL return the FSM to IDLE.
REQ-032 No new operand SHALL be accepted before that return to IDLE; no bypass path is provided.

Reset
REQ-033 While rst = 1, the state SHALL be IDLE, out_valid = 0, out_f = 0, out_exc = 0 and in_ready = 1.
REQ-034 Reset asserted mid-operation SHALL abort the operand with no output produced.
REQ-035 The first edge after reset deassertion SHALL be able to accept an operand.

Verification (NEXP=5, NSIG=10)
REQ-036 NORMAL, exp 0, in_sig 0x1000, rm RNE -> out_f 0x3C00, exc 0, out_valid after 2nd edge.
REQ-037 SUBNORMAL, exp -15, in_sig 0x1000 -> out_f 0x0200, exc 0; exactly 1 right shift.
REQ-038 NORMAL, exp 16, in_sig 0x1000:
- rm RNE -> out_f 0x7C00, exc {0,1,0,1}.
- rm RTZ -> out_f 0x7BFF, same exc.
REQ-039 NORMAL, exp 0, in_sig 0x1FFE, sticky 0, rm RNE -> out_f 0x4000, inexact only.
REQ-040 SNAN flag with out_ready held low 3 cycles -> out_f 0x7E00 and exc {1,0,0,0} stable for all 3 cycles, in_ready 0; handshake completes when out_ready rises.
REQ-041 NORMAL, exp 0, in_sig 0x0001, rst pulsed on the 3rd NORM cycle -> out_valid 0, in_ready 1. A following 1.0 operand -> 0x3C00.
